score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//   Owns the game score and high score and schedules what the 2-digit 7-segment score transcoder shows.
//   Sits between the snake game FSM (start/food/over pulses) and the score-to-segments transcoder.
//   Drives the transcoder's 7-bit input with current score or high score, plus a blank strobe for blinking.
//   Alternates and blinks the two values after game over.
// PARAMETERS
//   BLINK_HALF  25_000_000  clk cycles per blink half-period (0.5 s at 50 MHz); >=2
//   ALT_HALVES  4           blink half-periods per display source in OVER state; >=1
// PORTS
//   clk          in   1  system clock; all logic on rising edge
//   rst          in   1  synchronous, active-high reset
//   game_start   in   1  1-cycle pulse: new game begins
//   food_eaten   in   1  1-cycle pulse: snake ate food (+1 point)
//   game_over    in   1  1-cycle pulse: snake died
//   disp_val     out  7  value to transcoder input, {1'b0, 6-bit score}, range 0..63
//   disp_blank   out  1  1 = display driver forces all segments/anodes off
//   disp_src     out  1  0 = disp_val shows score, 1 = shows high score
//   score        out  6  current score
//   high_score   out  6  best score since reset
//   new_record   out  1  1 = last finished game set a new high score
//   state        out  2  00 IDLE, 01 PLAY, 10 OVER
// BEHAVIOUR
//   Reset (rst sampled high): state=IDLE, score=0, high_score=0, disp_val=0, disp_blank=0,
//     disp_src=1, new_record=0, blink timer=0, blink_phase=0, alt count=0. rst overrides all inputs.
//   All outputs are registers. An input pulse sampled at edge N is visible on outputs after edge N (1-cycle latency).
//   disp_val always equals {1'b0, disp_src ? high_score : score} as registered at the same edge.
//   FSM:
//     IDLE: disp_src=1, disp_blank=0, timers held at 0. game_start -> PLAY, score<=0, new_record<=0.
//       food_eaten/game_over ignored.
//     PLAY: disp_src=0, disp_blank=0. food_eaten -> score<=score+1, saturating at 63 (no wrap).
//       game_start -> restart: score<=0, stay PLAY. game_over -> OVER.
//     OVER: game_start -> PLAY, score<=0, new_record<=0. food_eaten/game_over ignored.
//   PLAY->OVER edge: final = score + food_eaten (saturated). score<=final.
//     If final > high_score: high_score<=final, new_record<=1; equal does not count as a record.
//     Blink timer, blink_phase and alt count cleared to 0; disp_src<=0; disp_blank<=0.
//   OVER timing:
//     The blink timer counts 0..BLINK_HALF-1 and wraps. On each wrap blink_phase toggles, and disp_blank=blink_phase.
//     Alt count increments on each wrap. When it reaches ALT_HALVES it clears to 0 and disp_src toggles.
//     Toggling disp_src also clears blink_phase to 0.
//     So each source shows ALT_HALVES half-periods starting visible, alternating lit/blank.
//   Simultaneous pulses (priority): rst > game_start > game_over > food_eaten.
//     In PLAY, food_eaten+game_over in the same cycle: the point counts, then OVER.
//     game_start with any other pulse: restart only.
//   Leaving OVER: timers cleared, disp_blank<=0 on the same edge.
//   Counters sized to clog2(BLINK_HALF) and clog2(ALT_HALVES+1); no overflow reachable.
// TESTING (bench uses BLINK_HALF=4, ALT_HALVES=2)
//   1 Reset:
//     rst for 2 clk -> state=00, score=0, high_score=0, disp_val=0, disp_src=1, disp_blank=0.
//   2 Scoring:
//     game_start, then 5 food_eaten pulses -> state=01, score=5, disp_val=7'd5, disp_src=0.
//   3 Saturation:
//     70 food_eaten pulses in PLAY -> score=63, disp_val=7'd63, no wrap to 0.
//   4 Record and blink:
//     Score 5, then game_over -> high_score=5, new_record=1, state=10.
//     disp_blank sequence 0x4, 1x4, then disp_src=1, disp_val=5, disp_blank=0x4, 1x4, then disp_src=0.
//   5 No record:
//     game_start, 3 food, game_over -> high_score stays 5, new_record=0.
//     game_start in OVER -> next cycle state=01, score=0, disp_blank=0.
//   6 Simultaneous and reset mid-play:
//     Score 62, food_eaten+game_over same cycle -> score=63, high_score=63, state=10.
//     rst mid-OVER -> all reset values next cycle.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Score/high-score keeper and transcoder display scheduler (blink + alternate after game over).
// Latency: all outputs registered, one cycle after the input pulse; no backpressure, pulses always accepted.
module score_display_ctrl #(
   parameter int BLINK_HALF = 25_000_000,
   parameter int ALT_HALVES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_start,
   input  logic       food_eaten,
   input  logic       game_over,
   output logic [6:0] disp_val,
   output logic       disp_blank,
   output logic       disp_src,
   output logic [5:0] score,
   output logic [5:0] high_score,
   output logic       new_record,
   output logic [1:0] state
);

   localparam int TW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int AW = $clog2(ALT_HALVES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(BLINK_HALF - 1);
   localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_HALVES);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_OVER = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [5:0]    score_q, score_d;
   logic [5:0]    high_q, high_d;
   logic          rec_q, rec_d;
   logic          src_q, src_d;
   logic          blank_q, blank_d;
   logic [6:0]    val_q, val_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          phase_q, phase_d;
   logic [AW-1:0] alt_q, alt_d;
   logic [5:0]    score_inc;
   logic [5:0]    final_score;
   logic [AW-1:0] alt_inc;

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      high_d      = high_q;
      rec_d       = rec_q;
      src_d       = src_q;
      blank_d     = blank_q;
      timer_d     = timer_q;
      phase_d     = phase_q;
      alt_d       = alt_q;
      score_inc   = (score_q == 6'd63) ? score_q : score_q + 6'd1;
      final_score = food_eaten ? score_inc : score_q;
      alt_inc     = alt_q + AW'(1);

      case (state_q)
         ST_IDLE: begin
            src_d   = 1'b1;
            blank_d = 1'b0;
            timer_d = '0;
            phase_d = 1'b0;
            alt_d   = '0;
            if (game_start) begin
               state_d = ST_PLAY;
               score_d = 6'd0;
               rec_d   = 1'b0;
               src_d   = 1'b0;
            end
         end
         ST_PLAY: begin
            src_d   = 1'b0;
            blank_d = 1'b0;
            if (game_start) begin
               score_d = 6'd0;
            end else if (game_over) begin
               // A point scored on the dying cycle still counts toward the record.
               score_d = final_score;
               if (final_score > high_q) begin
                  high_d = final_score;
                  rec_d  = 1'b1;
               end
               state_d = ST_OVER;
               timer_d = '0;
               phase_d = 1'b0;
               alt_d   = '0;
            end else if (food_eaten) begin
               score_d = score_inc;
            end
         end
         ST_OVER: begin
            if (game_start) begin
               state_d = ST_PLAY;
               score_d = 6'd0;
               rec_d   = 1'b0;
               src_d   = 1'b0;
               blank_d = 1'b0;
               timer_d = '0;
               phase_d = 1'b0;
               alt_d   = '0;
            end else begin
               if (timer_q == TIMER_LAST) begin
                  timer_d = '0;
                  if (alt_inc == ALT_LAST) begin
                     // Each new source starts visible.
                     alt_d   = '0;
                     src_d   = ~src_q;
                     phase_d = 1'b0;
                  end else begin
                     alt_d   = alt_inc;
                     phase_d = ~phase_q;
                  end
               end else begin
                  timer_d = timer_q + TW'(1);
               end
               blank_d = phase_d;
            end
         end
         default: begin
            state_d = ST_IDLE;
            src_d   = 1'b1;
            blank_d = 1'b0;
            timer_d = '0;
            phase_d = 1'b0;
            alt_d   = '0;
         end
      endcase

      val_d = {1'b0, src_d ? high_d : score_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         score_q <= 6'd0;
         high_q  <= 6'd0;
         rec_q   <= 1'b0;
         src_q   <= 1'b1;
         blank_q <= 1'b0;
         val_q   <= 7'd0;
         timer_q <= '0;
         phase_q <= 1'b0;
         alt_q   <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         high_q  <= high_d;
         rec_q   <= rec_d;
         src_q   <= src_d;
         blank_q <= blank_d;
         val_q   <= val_d;
         timer_q <= timer_d;
         phase_q <= phase_d;
         alt_q   <= alt_d;
      end
   end

   assign disp_val   = val_q;
   assign disp_blank = blank_q;
   assign disp_src   = src_q;
   assign score      = score_q;
   assign high_score = high_q;
   assign new_record = rec_q;
   assign state      = state_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed scenarios plus random pulses against a cycle-count reference model.
module tb_score_display_ctrl;

   localparam int BH = 4;
   localparam int AH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       game_start = 1'b0;
   logic       food_eaten = 1'b0;
   logic       game_over = 1'b0;
   logic [6:0] disp_val;
   logic       disp_blank;
   logic       disp_src;
   logic [5:0] score;
   logic [5:0] high_score;
   logic       new_record;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: game state plus number of cycles spent in OVER.
   int m_state = 0;
   int m_score = 0;
   int m_high  = 0;
   int m_rec   = 0;
   int m_k     = 0;

   score_display_ctrl #(.BLINK_HALF(BH), .ALT_HALVES(AH)) dut (
      .clk        (clk),
      .rst        (rst),
      .game_start (game_start),
      .food_eaten (food_eaten),
      .game_over  (game_over),
      .disp_val   (disp_val),
      .disp_blank (disp_blank),
      .disp_src   (disp_src),
      .score      (score),
      .high_score (high_score),
      .new_record (new_record),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic s, input logic f, input logic o, input logic r);
      int fin;
      if (r) begin
         m_state = 0; m_score = 0; m_high = 0; m_rec = 0; m_k = 0;
      end else if (m_state == 0) begin
         if (s) begin m_state = 1; m_score = 0; m_rec = 0; end
      end else if (m_state == 1) begin
         if (s) m_score = 0;
         else if (o) begin
            fin = f ? ((m_score + 1 > 63) ? 63 : m_score + 1) : m_score;
            m_score = fin;
            if (fin > m_high) begin m_high = fin; m_rec = 1; end
            m_state = 2;
            m_k = 0;
         end else if (f) m_score = (m_score + 1 > 63) ? 63 : m_score + 1;
      end else begin
         if (s) begin m_state = 1; m_score = 0; m_rec = 0; end
         else m_k = m_k + 1;
      end
   endtask

   function automatic int exp_src();
      if (m_state == 0) return 1;
      if (m_state == 1) return 0;
      return ((m_k / BH) / AH) % 2;
   endfunction

   function automatic int exp_blank();
      if (m_state != 2) return 0;
      return ((m_k / BH) % AH) % 2;
   endfunction

   task automatic tick(input logic s, input logic f, input logic o, input logic r);
      game_start = s; food_eaten = f; game_over = o; rst = r;
      @(posedge clk);
      model_step(s, f, o, r);
      #1;
      game_start = 1'b0; food_eaten = 1'b0; game_over = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (score !== 6'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
      n_cmp++; if (high_score !== 6'd0) begin n_err++; $display("FAIL reset_high: got %0d want 0", high_score); end
      n_cmp++; if (disp_val !== 7'd0) begin n_err++; $display("FAIL reset_val: got %0d want 0", disp_val); end
      n_cmp++; if (disp_src !== 1'b1) begin n_err++; $display("FAIL reset_src: got %0b want 1", disp_src); end
      n_cmp++; if (disp_blank !== 1'b0) begin n_err++; $display("FAIL reset_blank: got %0b want 0", disp_blank); end
      n_cmp++; if (new_record !== 1'b0) begin n_err++; $display("FAIL reset_rec: got %0b want 0", new_record); end
   endtask

   task automatic test_scoring();
      tick(0, 1, 1, 0);
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL idle_ignore: got %0d want 0", state); end
      tick(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 1, 0, 0);
         tick(0, 0, 0, 0);
      end
      n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL scoring_state: got %0d want 1", state); end
      n_cmp++; if (score !== 6'd5) begin n_err++; $display("FAIL scoring_score: got %0d want 5", score); end
      n_cmp++; if (disp_val !== 7'd5) begin n_err++; $display("FAIL scoring_val: got %0d want 5", disp_val); end
      n_cmp++; if (disp_src !== 1'b0) begin n_err++; $display("FAIL scoring_src: got %0b want 0", disp_src); end
   endtask

   task automatic test_record_blink();
      tick(0, 0, 1, 0);
      n_cmp++; if (high_score !== 6'd5) begin n_err++; $display("FAIL record_high: got %0d want 5", high_score); end
      n_cmp++; if (new_record !== 1'b1) begin n_err++; $display("FAIL record_flag: got %0b want 1", new_record); end
      n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL record_state: got %0d want 2", state); end
      for (int i = 0; i < 18; i++) begin
         n_cmp++;
         if (disp_blank !== 1'((i / 4) % 2) || disp_src !== 1'((i / 8) % 2) || disp_val !== 7'd5) begin
            n_err++;
            $display("FAIL blink_seq[%0d]: got blank=%0b src=%0b val=%0d want blank=%0d src=%0d val=5",
                     i, disp_blank, disp_src, disp_val, (i / 4) % 2, (i / 8) % 2);
         end
         tick(0, 0, 0, 0);
      end
   endtask

   task automatic test_no_record();
      tick(1, 0, 0, 0);
      n_cmp++; if (state !== 2'b01 || score !== 6'd0) begin n_err++; $display("FAIL restart_from_over: got state=%0d score=%0d want 1/0", state, score); end
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
      tick(0, 0, 1, 0);
      n_cmp++; if (high_score !== 6'd5) begin n_err++; $display("FAIL norec_high: got %0d want 5", high_score); end
      n_cmp++; if (new_record !== 1'b0) begin n_err++; $display("FAIL norec_flag: got %0b want 0", new_record); end
      n_cmp++; if (score !== 6'd3) begin n_err++; $display("FAIL norec_score: got %0d want 3", score); end
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
      n_cmp++; if (disp_blank !== 1'b1) begin n_err++; $display("FAIL norec_blank_lit: got %0b want 1", disp_blank); end
      tick(1, 0, 0, 0);
      n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL leave_over_state: got %0d want 1", state); end
      n_cmp++; if (score !== 6'd0) begin n_err++; $display("FAIL leave_over_score: got %0d want 0", score); end
      n_cmp++; if (disp_blank !== 1'b0) begin n_err++; $display("FAIL leave_over_blank: got %0b want 0", disp_blank); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 70; i++) tick(0, 1, 0, 0);
      n_cmp++; if (score !== 6'd63) begin n_err++; $display("FAIL sat_score: got %0d want 63", score); end
      n_cmp++; if (disp_val !== 7'd63) begin n_err++; $display("FAIL sat_val: got %0d want 63", disp_val); end
   endtask

   task automatic test_simultaneous();
      tick(1, 1, 1, 0);
      n_cmp++; if (state !== 2'b01 || score !== 6'd0) begin n_err++; $display("FAIL start_priority: got state=%0d score=%0d want 1/0", state, score); end
      for (int i = 0; i < 62; i++) tick(0, 1, 0, 0);
      n_cmp++; if (score !== 6'd62) begin n_err++; $display("FAIL sim_pre: got %0d want 62", score); end
      tick(0, 1, 1, 0);
      n_cmp++; if (score !== 6'd63) begin n_err++; $display("FAIL sim_score: got %0d want 63", score); end
      n_cmp++; if (high_score !== 6'd63) begin n_err++; $display("FAIL sim_high: got %0d want 63", high_score); end
      n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL sim_state: got %0d want 2", state); end
      for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
      tick(1, 1, 1, 1);
      n_cmp++;
      if (state !== 2'b00 || score !== 6'd0 || high_score !== 6'd0 || disp_val !== 7'd0 ||
          disp_src !== 1'b1 || disp_blank !== 1'b0 || new_record !== 1'b0) begin
         n_err++;
         $display("FAIL mid_over_reset: got st=%0d sc=%0d hi=%0d val=%0d src=%0b blk=%0b rec=%0b want 0/0/0/0/1/0/0",
                  state, score, high_score, disp_val, disp_src, disp_blank, new_record);
      end
   endtask

   task automatic test_random();
      logic [23:0] got, want;
      for (int c = 0; c < 3000; c++) begin
         tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));
         want = {2'(m_state), 6'(m_score), 6'(m_high), 1'(m_rec), 1'(exp_src()), 1'(exp_blank()),
                 7'(exp_src() != 0 ? m_high : m_score)};
         got  = {state, score, high_score, new_record, disp_src, disp_blank, disp_val};
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL random[%0d]: got %h want %h (st,sc,hi,rec,src,blk,val)", c, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scoring();
      test_record_blink();
      test_no_record();
      test_saturation();
      test_simultaneous();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
